// File: rtl/if_id_hazard.sv
// rtl/if_id_hazard.sv - IF/ID pipeline register with load-use stall and redirect flush control
module if_id_hazard #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          Instruction_if,
    input  logic [31:0]          NextPC_if,
    input  logic                 Z,
    input  logic                 J,
    input  logic                 JR,
    input  logic                 MemRead_ex,
    input  logic [4:0]           Rt_ex,
    output logic                 PC_IFWrite,
    output logic [31:0]          Instruction_id,
    output logic [31:0]          NextPC_id,
    output logic                 Valid_id,
    output logic                 Bubble_id,
    output logic [CNT_WIDTH-1:0] Stall_count,
    output logic [CNT_WIDTH-1:0] Flush_count
);

    typedef enum logic {RUN, STALL} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t               state_q;
    logic [31:0]          instr_q, instr_d;
    logic [31:0]          npc_q, npc_d;
    logic                 valid_q, valid_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic redirect;
    logic hazard;
    logic stall;

    assign redirect = Z | J | JR;

    // Only one stall per load: the STALL state masks the hazard on its second cycle.
    assign hazard = (state_q == RUN) && valid_q && MemRead_ex && (Rt_ex != 5'd0) &&
                    ((Rt_ex == instr_q[25:21]) || (Rt_ex == instr_q[20:16]));
    assign stall  = hazard & ~redirect;

    assign PC_IFWrite     = reset | ~stall;
    assign Bubble_id      = reset | stall | ~valid_q;
    assign Instruction_id = instr_q;
    assign NextPC_id      = npc_q;
    assign Valid_id       = valid_q;
    assign Stall_count    = stall_cnt_q;
    assign Flush_count    = flush_cnt_q;

    always_comb begin
        instr_d     = instr_q;
        npc_d       = npc_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (redirect) begin
            instr_d = 32'h0;
            npc_d   = 32'h0;
            valid_d = 1'b0;
        end else if (!stall) begin
            instr_d = Instruction_if;
            npc_d   = NextPC_if;
            valid_d = 1'b1;
        end
        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (redirect && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            instr_q     <= 32'h0;
            npc_q       <= 32'h0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= stall ? STALL : RUN;
            instr_q     <= instr_d;
            npc_q       <= npc_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: doc/if_id_hazard.md
IF_ID_HAZARD -- requirements
Module: if_id_hazard

Interface
REQ-001 Parameter CNT_WIDTH, default 16, width of each saturating event counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Instruction_if  input  32  instruction fetched this cycle.
REQ-005 NextPC_if  input  32  PC+4 of the fetched instruction.
REQ-006 Z  input  1  taken-branch redirect.
REQ-007 J  input  1  jump redirect.
REQ-008 JR  input  1  jump-register redirect.
REQ-009 MemRead_ex  input  1  instruction in EX is a load.
REQ-010 Rt_ex  input  5  destination register of the load in EX.
REQ-011 PC_IFWrite  output  1  fetch-stage PC/clock enable; 0 holds the fetch stage.
REQ-012 Instruction_id  output  32  registered instruction presented to decode.
REQ-013 NextPC_id  output  32  registered PC+4 paired with Instruction_id.
REQ-014 Valid_id  output  1  Instruction_id is a real instruction, not a bubble.
REQ-015 Bubble_id  output  1  decode must insert a NOP into ID/EX this cycle.
REQ-016 Stall_count  output  CNT_WIDTH  number of load-use stall cycles since reset.
REQ-017 Flush_count  output  CNT_WIDTH  number of flush cycles since reset.

Function
REQ-018 Redirect = Z | J | JR, a combinational signal.
REQ-019 Hazard is 1 iff state = RUN, Valid_id = 1, MemRead_ex = 1, Rt_ex != 0, and Rt_ex equals Instruction_id[25:21] or Instruction_id[20:16].
REQ-020 The FSM has exactly two states, RUN and STALL, and resets to RUN.
REQ-021 RUN -> STALL when Hazard = 1 and Redirect = 0; STALL -> RUN unconditionally after one cycle.
REQ-022 Any other condition leaves the FSM in RUN, so at most one stall is taken per load.
REQ-023 Flush cycle (Redirect = 1): on the next edge, Instruction_id <= 32'h0, NextPC_id <= 32'h0, Valid_id <= 0.
REQ-024 Flush overrides stall: when Redirect = 1 and Hazard = 1 together, the block flushes, stays in RUN, and drives PC_IFWrite = 1.
REQ-025 Stall cycle (Hazard = 1, Redirect = 0): Instruction_id, NextPC_id and Valid_id hold their values, PC_IFWrite = 0 and Bubble_id = 1.
REQ-026 Normal cycle (neither flush nor stall): Instruction_id <= Instruction_if, NextPC_id <= NextPC_if, Valid_id <= 1.
REQ-027 PC_IFWrite = ~(Hazard & ~Redirect), a combinational, glitch-free decode of registered state plus inputs that are stable before the edge.
REQ-028 Bubble_id = (Hazard & ~Redirect) | ~Valid_id.
REQ-029 Stall_count increments by 1 on each stall cycle and saturates at 2^CNT_WIDTH-1 with no wrap.
REQ-030 Flush_count increments by 1 on each flush cycle and saturates at 2^CNT_WIDTH-1 with no wrap.
REQ-031 Latency from Instruction_if to Instruction_id is exactly one cycle when no stall or flush occurs.

Reset
REQ-032 While reset = 1 at an edge, the following are loaded: Instruction_id = 0, NextPC_id = 0, Valid_id = 0, state = RUN, Stall_count = 0, Flush_count = 0.
REQ-033 Reset overrides stall, flush and counter updates in the same cycle.
REQ-034 A reset asserted during STALL returns the FSM to RUN on that edge.
REQ-035 While reset = 1, PC_IFWrite = 1 and Bubble_id = 1.

Verification
REQ-036 Streaming: feed 0x8C010000, 0x00221820, 0x00000000 with all controls 0 -> each instruction appears one cycle later with Valid_id = 1 and PC_IFWrite = 1 throughout.
REQ-037 Load-use: Instruction_id = 0x00221820 (rs = 1), MemRead_ex = 1, Rt_ex = 1 -> PC_IFWrite = 0, Bubble_id = 1, Instruction_id held for one cycle, then advances; Stall_count = 1.
REQ-038 Zero register: Rt_ex = 0, MemRead_ex = 1, rs field = 0 -> no stall and Stall_count stays 0.
REQ-039 Simultaneous events: Hazard and Z = 1 in the same cycle -> PC_IFWrite = 1, next Instruction_id = 0, Valid_id = 0, Flush_count = 1, Stall_count = 0.
REQ-040 Saturation: with CNT_WIDTH = 2, apply 5 flush cycles -> Flush_count reads 3 and holds at 3.
REQ-041 Reset mid-stall: assert reset during the STALL cycle -> next cycle shows state RUN, all outputs at reset values, and both counters = 0.
